mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  MEM pipeline stage, between EX and WB. Holds one instruction and waits for the
//  data-SRAM response of loads and stores issued in EX. Extracts and extends load data.
//  Forwards the result to ID for bypass and stall decisions.
//  Discards SRAM responses that belong to requests killed by a WB flush.
// PARAMETERS
//  SIDE_W  64  width of the opaque CSR/TLB side-band field, passed unchanged to WB
// PORTS
//  clk               in   1            clock, all state updates on its rising edge
//  reset             in   1            asynchronous, active-high reset
//  ex_to_mem_valid   in   1            EX holds an instruction for MEM
//  ex_to_mem_bus     in   SIDE_W+124   {side,pc[31:0],rf_we,rf_waddr[4:0],alu_res[31:0],ld_op[4:0],mem_req,ex_en,ecode[5:0],esubcode[8:0],badv[31:0]}
//  ex_req_pending    in   1            EX holds an SRAM request already accepted (addr_ok seen)
//  mem_allowin       out  1            MEM can accept from EX this cycle
//  mem_to_ex_ex      out  1            MEM instruction carries an exception; EX must suppress new stores
//  data_sram_data_ok in   1            SRAM response valid, one per accepted request, in order
//  data_sram_rdata   in   32           SRAM read data
//  wb_allowin        in   1            WB can accept
//  mem_to_wb_valid   out  1            MEM presents an instruction to WB
//  mem_to_wb_bus     out  SIDE_W+118   {side,pc,rf_we,rf_waddr,rf_wdata[31:0],ex_en,ecode,esubcode,badv}
//  mem_to_id_bus     out  39           {fwd_we,fwd_waddr[4:0],fwd_wdata[31:0],load_stall}
//  flush             in   1            WB exception, ertn or refetch; kills MEM and all younger stages
// BEHAVIOUR
//  Reset: mem_valid=0, drop_cnt=0, buf_valid=0, payload registers=0.
//    Hence mem_allowin=1, mem_to_wb_valid=0, mem_to_ex_ex=0, mem_to_id_bus=0.
//  Accept: when ex_to_mem_valid & mem_allowin, latch the bus and set mem_valid=1.
//    When only mem_allowin is high, set mem_valid=0.
//    flush has priority: mem_valid<=0 at the next edge.
//  Handshake:
//    ready_go        = ~mem_req_r | buf_valid | (data_sram_data_ok & drop_cnt==0)
//    mem_allowin     = ~mem_valid | (ready_go & wb_allowin)
//    mem_to_wb_valid = mem_valid & ready_go & ~flush
//  Response buffer: data_ok that arrives for the live instruction (drop_cnt==0) while
//    wb_allowin=0 is captured in buf_data with buf_valid=1.
//    buf_valid clears when the instruction leaves MEM or when flush is asserted.
//  Drop counter: 2 bits, tracks responses still owed to killed requests.
//    On flush: drop_cnt += (mem_valid & mem_req_r & ~buf_valid & ~data_ok_this_cycle) + ex_req_pending.
//    Each data_ok seen while drop_cnt>0 is discarded and drop_cnt -= 1; such a data_ok never satisfies ready_go.
//    A flush and a discarded data_ok in the same cycle update the count by the net sum.
//    drop_cnt never exceeds 2.
//  Load data: select raw word = buf_valid ? buf_data : data_sram_rdata.
//    ld_op is one-hot {w,hu,h,bu,b}; alu_res[1:0] selects the byte or halfword.
//    b/h sign-extend; bu/hu zero-extend; w passes the word unchanged.
//    rf_wdata = (|ld_op) ? extended load : alu_res.
//  Exceptions: when ex_en=1, MEM forwards the instruction to WB unchanged.
//    If ex_en=1, mem_req is 0 by construction, so the instruction never waits for data.
//    mem_to_ex_ex = mem_valid & ex_en.
//  ID forward:
//    fwd_we     = mem_valid & rf_we & ~ex_en
//    load_stall = mem_valid & (|ld_op) & ~ready_go
//    fwd_wdata  = rf_wdata
//  Reset mid-request: drop_cnt is cleared. The SRAM is reset by the same reset, so no
//    stale response arrives afterwards.
// TESTING
//  1 ld.w at addr 0x1000, data_ok 2 cycles later with rdata=0x8765_4321, wb_allowin=1 ->
//    mem_to_wb_valid rises in the data_ok cycle; rf_wdata=0x8765_4321; load_stall=1 for the cycles before data_ok.
//  2 ld.b with addr[1:0]=3 and rdata=0x80xx_xxxx -> rf_wdata=0xFFFF_FF80; same case with ld.bu -> 0x0000_0080.
//  3 data_ok arrives while wb_allowin=0 -> buf_valid=1; rdata changes afterwards;
//    when wb_allowin rises, WB receives the buffered value.
//  4 flush while MEM waits on a load and ex_req_pending=1 -> drop_cnt=2; the next two data_ok pulses are discarded;
//    the third data_ok completes the next accepted load correctly.
//  5 MEM holds an instruction with ex_en=1 and ecode=0x08 -> mem_to_ex_ex=1, fwd_we=0;
//    the instruction passes to WB next cycle with ecode preserved.
//  6 reset asserted while MEM waits on data_ok -> outputs go to reset values immediately
//    (reset is asynchronous); mem_allowin=1.

Source files
------------

// File: rtl/mem_stage_if.sv
// EX/MEM/WB/SRAM-facing signal bundle of the MEM pipeline stage.
// The slave modport is the stage itself; the master modport is its environment.
interface mem_stage_if #(
  parameter int SIDE_W = 64
);
  logic                ex_to_mem_valid;
  logic [SIDE_W+123:0] ex_to_mem_bus;
  logic                ex_req_pending;
  logic                mem_allowin;
  logic                mem_to_ex_ex;
  logic                data_sram_data_ok;
  logic [31:0]         data_sram_rdata;
  logic                wb_allowin;
  logic                mem_to_wb_valid;
  logic [SIDE_W+117:0] mem_to_wb_bus;
  logic [38:0]         mem_to_id_bus;
  logic                flush;

  modport master (
    output ex_to_mem_valid, ex_to_mem_bus, ex_req_pending,
    output data_sram_data_ok, data_sram_rdata, wb_allowin, flush,
    input  mem_allowin, mem_to_ex_ex, mem_to_wb_valid, mem_to_wb_bus, mem_to_id_bus
  );

  modport slave (
    input  ex_to_mem_valid, ex_to_mem_bus, ex_req_pending,
    input  data_sram_data_ok, data_sram_rdata, wb_allowin, flush,
    output mem_allowin, mem_to_ex_ex, mem_to_wb_valid, mem_to_wb_bus, mem_to_id_bus
  );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: waits for data-SRAM responses, extends load data, forwards to ID,
// and discards responses still owed to requests killed by a WB flush.
module mem_stage #(
  parameter int SIDE_W = 64
) (
  input  logic        clk,
  input  logic        reset,
  mem_stage_if.slave  io
);
  localparam int IN_W = SIDE_W + 124;

  logic            mem_valid_reg;
  logic [IN_W-1:0] payload_reg;
  logic            buf_valid_reg;
  logic [31:0]     buf_data_reg;
  logic [1:0]      drop_cnt_reg;
  logic [1:0]      drop_cnt_next;

  logic [SIDE_W-1:0] side;
  logic [31:0]       pc;
  logic              rf_we;
  logic [4:0]        rf_waddr;
  logic [31:0]       alu_res;
  logic [4:0]        ld_op;
  logic              mem_req;
  logic              ex_en;
  logic [5:0]        ecode;
  logic [8:0]        esubcode;
  logic [31:0]       badv;

  assign side     = payload_reg[IN_W-1:124];
  assign pc       = payload_reg[123:92];
  assign rf_we    = payload_reg[91];
  assign rf_waddr = payload_reg[90:86];
  assign alu_res  = payload_reg[85:54];
  assign ld_op    = payload_reg[53:49];
  assign mem_req  = payload_reg[48];
  assign ex_en    = payload_reg[47];
  assign ecode    = payload_reg[46:41];
  assign esubcode = payload_reg[40:32];
  assign badv     = payload_reg[31:0];

  logic data_ok_live;
  logic ready_go;
  logic allowin;
  logic to_wb_valid;
  logic owed_now;
  logic drop_dec;
  logic [1:0] drop_inc;

  // A response only belongs to the live instruction once all killed ones are drained.
  assign data_ok_live = io.data_sram_data_ok & (drop_cnt_reg == 2'd0);
  assign ready_go     = ~mem_req | buf_valid_reg | data_ok_live;
  assign allowin      = ~mem_valid_reg | (ready_go & io.wb_allowin);
  assign to_wb_valid  = mem_valid_reg & ready_go & ~io.flush;

  assign owed_now      = mem_valid_reg & mem_req & ~buf_valid_reg & ~data_ok_live;
  assign drop_dec      = io.data_sram_data_ok & (drop_cnt_reg != 2'd0);
  assign drop_inc      = io.flush ? ({1'b0, owed_now} + {1'b0, io.ex_req_pending}) : 2'd0;
  assign drop_cnt_next = drop_cnt_reg + drop_inc - {1'b0, drop_dec};

  logic [31:0] raw_word;
  logic [7:0]  lanes [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_val;
  logic [31:0] rf_wdata;

  assign raw_word = buf_valid_reg ? buf_data_reg : io.data_sram_rdata;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lanes[gi] = raw_word[8*gi +: 8];
  end

  assign byte_sel = lanes[alu_res[1:0]];
  assign half_sel = alu_res[1] ? raw_word[31:16] : raw_word[15:0];

  // ld_op is one-hot {w,hu,h,bu,b}
  always_comb begin
    load_val = raw_word;
    if (ld_op[0])      load_val = {{24{byte_sel[7]}}, byte_sel};
    else if (ld_op[1]) load_val = {24'd0, byte_sel};
    else if (ld_op[2]) load_val = {{16{half_sel[15]}}, half_sel};
    else if (ld_op[3]) load_val = {16'd0, half_sel};
  end

  assign rf_wdata = (|ld_op) ? load_val : alu_res;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_valid_reg <= 1'b0;
      payload_reg   <= '0;
      buf_valid_reg <= 1'b0;
      buf_data_reg  <= '0;
      drop_cnt_reg  <= 2'd0;
    end else begin
      drop_cnt_reg <= drop_cnt_next;
      if (io.flush) begin
        mem_valid_reg <= 1'b0;
        buf_valid_reg <= 1'b0;
      end else if (allowin) begin
        mem_valid_reg <= io.ex_to_mem_valid;
        buf_valid_reg <= 1'b0;
        if (io.ex_to_mem_valid) begin
          payload_reg <= io.ex_to_mem_bus;
        end
      end else if (data_ok_live & mem_valid_reg & mem_req & ~buf_valid_reg) begin
        // WB is stalled: hold the response so the SRAM bus can move on
        buf_valid_reg <= 1'b1;
        buf_data_reg  <= io.data_sram_rdata;
      end
    end
  end

  assign io.mem_allowin     = allowin;
  assign io.mem_to_ex_ex    = mem_valid_reg & ex_en;
  assign io.mem_to_wb_valid = to_wb_valid;
  assign io.mem_to_wb_bus   = {side, pc, rf_we, rf_waddr, rf_wdata, ex_en, ecode, esubcode, badv};
  assign io.mem_to_id_bus   = {mem_valid_reg & rf_we & ~ex_en, rf_waddr, rf_wdata,
                               mem_valid_reg & (|ld_op) & ~ready_go};
endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios with literal expectations, then random traffic
// checked every cycle against a queue-based model of outstanding SRAM responses.
module tb_mem_stage;
  localparam int SIDE_W = 64;

  typedef struct {
    logic [63:0] side;
    logic [31:0] pc;
    logic        rf_we;
    logic [4:0]  waddr;
    logic [31:0] alu;
    logic [4:0]  ld_op;
    logic        mem_req;
    logic        ex_en;
    logic [5:0]  ecode;
    logic [8:0]  esub;
    logic [31:0] badv;
  } ins_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_stage_if #(.SIDE_W(SIDE_W)) mif();

  mem_stage #(.SIDE_W(SIDE_W)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (mif)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // EX-side bookkeeping (the bench plays EX and the SRAM)
  ins_t ex_ins;
  bit   ex_valid = 0;
  bit   ex_has_req = 0;
  int   ex_id = 0;
  int   next_id = 1;
  int   resp_q[$];          // owner id per outstanding response, -1 = killed

  // MEM-side model
  ins_t        m_ins;
  bit          m_valid = 0;
  bit          m_have = 0;
  logic [31:0] m_word = '0;
  int          m_id = 0;

  task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
  endtask

  function automatic logic [SIDE_W+123:0] pack_in(ins_t i);
    return {i.side, i.pc, i.rf_we, i.waddr, i.alu, i.ld_op, i.mem_req, i.ex_en, i.ecode, i.esub, i.badv};
  endfunction

  function automatic ins_t rand_ins(int kind);
    ins_t i;
    i.side    = {$urandom, $urandom};
    i.pc      = $urandom;
    i.rf_we   = 1'($urandom_range(0, 1));
    i.waddr   = 5'($urandom);
    i.alu     = $urandom;
    i.ld_op   = 5'd0;
    i.mem_req = 1'b0;
    i.ex_en   = 1'b0;
    i.ecode   = 6'd0;
    i.esub    = 9'd0;
    i.badv    = $urandom;
    case (kind)
      1: begin i.ld_op = 5'(1 << $urandom_range(0, 4)); i.mem_req = 1'b1; i.rf_we = 1'b1; end
      2: begin i.mem_req = 1'b1; i.rf_we = 1'b0; end
      3: begin i.ex_en = 1'b1; i.ecode = 6'($urandom); i.esub = 9'($urandom); end
      default: ;
    endcase
    return i;
  endfunction

  // Load extraction from plain shifts: b/h sign-extend, bu/hu zero-extend, w as is
  function automatic logic [31:0] ldext(logic [4:0] op, logic [1:0] a, logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * int'(a))) & 32'hFF;
    h = (w >> (16 * int'(a[1]))) & 32'hFFFF;
    case (op)
      5'b00001: return (b ^ 32'h80) - 32'h80;
      5'b00010: return b;
      5'b00100: return (h ^ 32'h8000) - 32'h8000;
      5'b01000: return h;
      default:  return w;
    endcase
  endfunction

  task automatic wait_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic put_ex(ins_t i);
    ex_ins = i;
    ex_valid = 1;
    ex_has_req = 0;
    ex_id = next_id++;
  endtask

  task automatic issue();
    ex_has_req = 1;
    resp_q.push_back(ex_id);
  endtask

  task automatic apply(bit dok, logic [31:0] rd, bit wba, bit fl);
    mif.ex_to_mem_valid   = ex_valid && (!ex_ins.mem_req || ex_has_req);
    mif.ex_to_mem_bus     = pack_in(ex_ins);
    mif.ex_req_pending    = ex_has_req;
    mif.data_sram_data_ok = dok;
    mif.data_sram_rdata   = rd;
    mif.wb_allowin        = wba;
    mif.flush             = fl;
    #1;
  endtask

  // Compare process: checks outputs mid-cycle, then advances the model for the coming edge
  bit          c_fl, c_dok, c_wba, front_live, c_ready, e_wbv, e_allow, e_fwe, e_stall, e_exex;
  logic [31:0] c_word, e_wd;
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        m_valid = 0; m_have = 0; ex_valid = 0; ex_has_req = 0;
        resp_q.delete();
      end else begin
        c_fl  = mif.flush;
        c_dok = mif.data_sram_data_ok;
        c_wba = mif.wb_allowin;
        front_live = c_dok && resp_q.size() > 0 && resp_q[0] != -1;
        c_ready = !m_ins.mem_req || m_have || front_live;
        e_wbv   = m_valid && c_ready && !c_fl;
        e_allow = !m_valid || (c_ready && c_wba);
        c_word  = m_have ? m_word : mif.data_sram_rdata;
        e_wd    = (|m_ins.ld_op) ? ldext(m_ins.ld_op, m_ins.alu[1:0], c_word) : m_ins.alu;
        e_exex  = m_valid && m_ins.ex_en;
        e_fwe   = m_valid && m_ins.rf_we && !m_ins.ex_en;
        e_stall = m_valid && (|m_ins.ld_op) && !c_ready;

        chk("allowin", mif.mem_allowin, e_allow);
        chk("wb_valid", mif.mem_to_wb_valid, e_wbv);
        chk("to_ex_ex", mif.mem_to_ex_ex, e_exex);
        chk("fwd_we", mif.mem_to_id_bus[38], e_fwe);
        chk("load_stall", mif.mem_to_id_bus[0], e_stall);
        if (e_wbv)
          chk("wb_bus", mif.mem_to_wb_bus, {m_ins.side, m_ins.pc, m_ins.rf_we, m_ins.waddr, e_wd,
                                            m_ins.ex_en, m_ins.ecode, m_ins.esub, m_ins.badv});
        if (e_fwe && !e_stall)
          chk("id_fwd", mif.mem_to_id_bus[37:1], {m_ins.waddr, e_wd});

        if (c_dok && resp_q.size() > 0) void'(resp_q.pop_front());
        if (c_fl) begin
          foreach (resp_q[k]) resp_q[k] = -1;
          m_valid = 0; m_have = 0; ex_valid = 0; ex_has_req = 0;
        end else begin
          if (front_live && !(e_wbv && c_wba)) begin
            m_have = 1;
            m_word = mif.data_sram_rdata;
          end
          if (e_allow) begin
            if (mif.ex_to_mem_valid) begin
              m_valid = 1; m_ins = ex_ins; m_id = ex_id; m_have = 0;
              ex_valid = 0; ex_has_req = 0;
            end else begin
              m_valid = 0; m_have = 0;
            end
          end
        end
      end
    end
  end

  task automatic run_load(string name, logic [4:0] op, logic [31:0] addr, int delay,
                          logic [31:0] rd, logic [31:0] exp);
    ins_t i;
    i = rand_ins(1);
    i.ld_op = op;
    i.alu = addr;
    wait_edge(); put_ex(i); issue(); apply(0, $urandom, 1, 0);
    repeat (delay) begin
      wait_edge(); apply(0, $urandom, 1, 0);
      chk({name, "_stall"}, mif.mem_to_id_bus[0], 1'b1);
      chk({name, "_wbv_wait"}, mif.mem_to_wb_valid, 1'b0);
    end
    wait_edge(); apply(1, rd, 1, 0);
    chk({name, "_wbv"}, mif.mem_to_wb_valid, 1'b1);
    chk({name, "_wdata"}, mif.mem_to_id_bus[32:1], exp);
  endtask

  ins_t t;
  bit   legal;
  initial begin
    m_ins = rand_ins(0);
    ex_ins = rand_ins(0);
    apply(0, 0, 0, 0);
    #10;
    chk("rst_allowin", mif.mem_allowin, 1'b1);
    chk("rst_wbv", mif.mem_to_wb_valid, 1'b0);
    chk("rst_exex", mif.mem_to_ex_ex, 1'b0);
    chk("rst_id_bus", mif.mem_to_id_bus, 39'd0);
    wait_edge();
    reset = 1'b0;

    run_load("t1_ldw", 5'b10000, 32'h1000, 2, 32'h8765_4321, 32'h8765_4321);
    run_load("t2_ldb", 5'b00001, 32'h1003, 0, 32'h8012_3456, 32'hFFFF_FF80);
    run_load("t2_ldbu", 5'b00010, 32'h1003, 0, 32'h8012_3456, 32'h0000_0080);
    run_load("t2_ldh", 5'b00100, 32'h1002, 1, 32'h8001_7777, 32'hFFFF_8001);
    run_load("t2_ldhu", 5'b01000, 32'h1002, 0, 32'h8001_7777, 32'h0000_8001);

    // buffered response while WB stalls
    t = rand_ins(1); t.ld_op = 5'b10000;
    wait_edge(); put_ex(t); issue(); apply(0, $urandom, 1, 0);
    wait_edge(); apply(1, 32'hCAFE_BABE, 0, 0);
    chk("t3_wbv_ok", mif.mem_to_wb_valid, 1'b1);
    wait_edge(); apply(0, 32'h1111_1111, 0, 0);
    chk("t3_buf_wdata", mif.mem_to_id_bus[32:1], 32'hCAFE_BABE);
    wait_edge(); apply(0, 32'h2222_2222, 1, 0);
    chk("t3_wb_wdata", mif.mem_to_wb_bus[79:48], 32'hCAFE_BABE);

    // flush with MEM waiting and EX holding an accepted request
    t = rand_ins(1); t.ld_op = 5'b10000;
    wait_edge(); put_ex(t); issue(); apply(0, $urandom, 1, 0);
    t = rand_ins(1);
    wait_edge(); put_ex(t); issue(); apply(0, $urandom, 1, 0);
    wait_edge(); apply(0, $urandom, 1, 1);
    chk("t4_flush_wbv", mif.mem_to_wb_valid, 1'b0);
    t = rand_ins(1); t.ld_op = 5'b10000;
    wait_edge(); put_ex(t); issue(); apply(0, $urandom, 1, 0);
    wait_edge(); apply(1, 32'hDEAD_0001, 1, 0);
    chk("t4_drop1_wbv", mif.mem_to_wb_valid, 1'b0);
    chk("t4_drop1_stall", mif.mem_to_id_bus[0], 1'b1);
    wait_edge(); apply(1, 32'hDEAD_0002, 1, 0);
    chk("t4_drop2_wbv", mif.mem_to_wb_valid, 1'b0);
    wait_edge(); apply(1, 32'h1234_5678, 1, 0);
    chk("t4_live_wbv", mif.mem_to_wb_valid, 1'b1);
    chk("t4_live_wdata", mif.mem_to_id_bus[32:1], 32'h1234_5678);

    // exception instruction passes straight through
    t = rand_ins(3); t.ecode = 6'h08; t.rf_we = 1'b1;
    wait_edge(); put_ex(t); apply(0, $urandom, 1, 0);
    wait_edge(); apply(0, $urandom, 0, 0);
    chk("t5_exex", mif.mem_to_ex_ex, 1'b1);
    chk("t5_fwd_we", mif.mem_to_id_bus[38], 1'b0);
    chk("t5_wbv", mif.mem_to_wb_valid, 1'b1);
    wait_edge(); apply(0, $urandom, 1, 0);
    chk("t5_ecode", mif.mem_to_wb_bus[46:41], 6'h08);

    // asynchronous reset while a load waits
    t = rand_ins(1); t.ld_op = 5'b10000;
    wait_edge(); put_ex(t); issue(); apply(0, $urandom, 1, 0);
    wait_edge(); apply(0, $urandom, 1, 0);
    chk("t6_pre_stall", mif.mem_to_id_bus[0], 1'b1);
    reset = 1'b1;
    #1;
    chk("t6_allowin", mif.mem_allowin, 1'b1);
    chk("t6_wbv", mif.mem_to_wb_valid, 1'b0);
    chk("t6_exex", mif.mem_to_ex_ex, 1'b0);
    chk("t6_id_bus", mif.mem_to_id_bus, 39'd0);
    wait_edge();
    reset = 1'b0;
    apply(0, 0, 1, 0);

    repeat (4000) begin
      wait_edge();
      if (!ex_valid && $urandom_range(0, 9) < 7) put_ex(rand_ins(int'($urandom_range(0, 3))));
      if (ex_valid && ex_ins.mem_req && !ex_has_req && resp_q.size() < 2 && $urandom_range(0, 9) < 6)
        issue();
      legal = resp_q.size() > 0 && (resp_q[0] == -1 || (m_valid && resp_q[0] == m_id && !m_have));
      apply(legal && $urandom_range(0, 9) < 5, $urandom, $urandom_range(0, 9) < 7,
            $urandom_range(0, 29) == 0);
    end

    wait_edge();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
